// File: rtl/axi_slice_pkg.sv
// Shared types and field widths for the AXI4 register slice.
// Channel mode selection plus fixed AXI4 sideband widths.
package axi_slice_pkg;

  typedef enum logic [1:0] {
    SLICE_BYPASS = 2'd0,
    SLICE_FULL   = 2'd1,
    SLICE_HALF   = 2'd2
  } slice_mode_e;

  localparam int AXI_LEN_W   = 8;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_CACHE_W = 4;
  localparam int AXI_PROT_W  = 3;
  localparam int AXI_RESP_W  = 2;

endpackage

// File: rtl/axi_reg_slice_if.sv
// AXI4 bundle with master/slave views.
// Widths follow the slice parameters.
interface axi_reg_slice_if
  import axi_slice_pkg::*;
#(
  parameter int ID_WIDTH   = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128
);

  localparam int STRB_W = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]    aw_id;
  logic [ADDR_WIDTH-1:0]  aw_addr;
  logic [AXI_LEN_W-1:0]   aw_len;
  logic [AXI_SIZE_W-1:0]  aw_size;
  logic [AXI_BURST_W-1:0] aw_burst;
  logic                   aw_lock;
  logic [AXI_CACHE_W-1:0] aw_cache;
  logic [AXI_PROT_W-1:0]  aw_prot;
  logic                   aw_valid;
  logic                   aw_ready;

  logic [DATA_WIDTH-1:0]  w_data;
  logic [STRB_W-1:0]      w_strb;
  logic                   w_last;
  logic                   w_valid;
  logic                   w_ready;

  logic [ID_WIDTH-1:0]    b_id;
  logic [AXI_RESP_W-1:0]  b_resp;
  logic                   b_valid;
  logic                   b_ready;

  logic [ID_WIDTH-1:0]    ar_id;
  logic [ADDR_WIDTH-1:0]  ar_addr;
  logic [AXI_LEN_W-1:0]   ar_len;
  logic [AXI_SIZE_W-1:0]  ar_size;
  logic [AXI_BURST_W-1:0] ar_burst;
  logic                   ar_lock;
  logic [AXI_CACHE_W-1:0] ar_cache;
  logic [AXI_PROT_W-1:0]  ar_prot;
  logic                   ar_valid;
  logic                   ar_ready;

  logic [ID_WIDTH-1:0]    r_id;
  logic [DATA_WIDTH-1:0]  r_data;
  logic [AXI_RESP_W-1:0]  r_resp;
  logic                   r_last;
  logic                   r_valid;
  logic                   r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size,
    output aw_burst, aw_lock, aw_cache, aw_prot,
    output aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size,
    output ar_burst, ar_lock, ar_cache, ar_prot,
    output ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size,
    input  aw_burst, aw_lock, aw_cache, aw_prot,
    input  aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_valid,
    output w_ready,
    output b_id, b_resp, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size,
    input  ar_burst, ar_lock, ar_cache, ar_prot,
    input  ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_valid,
    input  r_ready
  );

endinterface

// File: rtl/axi_slice_chan.sv
// Generic valid/ready register slice for one channel payload.
// Bypass, two-entry skid buffer or single half-rate register.
module axi_slice_chan
  import axi_slice_pkg::*;
#(
  parameter int          WIDTH = 32,
  parameter slice_mode_e MODE  = SLICE_FULL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  if (MODE == SLICE_BYPASS) begin : g_bypass

    assign out_valid = in_valid;
    assign out_data  = in_data;
    assign in_ready  = out_ready;

  end else if (MODE == SLICE_FULL) begin : g_full

    logic             main_vld;
    logic             main_vld_n;
    logic             skid_vld;
    logic             skid_vld_n;
    logic             load_main;
    logic             load_skid;
    logic             pop_skid;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    assign in_ready  = !skid_vld;
    assign out_valid = main_vld;
    assign out_data  = main_q;

    // main refills when empty or draining; skid only catches a stalled accept
    always_comb begin
      main_vld_n = main_vld;
      skid_vld_n = skid_vld;
      load_main  = 1'b0;
      load_skid  = 1'b0;
      pop_skid   = 1'b0;
      if (!main_vld || out_ready) begin
        if (skid_vld) begin
          pop_skid   = 1'b1;
          main_vld_n = 1'b1;
          skid_vld_n = 1'b0;
        end else begin
          load_main  = in_valid;
          main_vld_n = in_valid;
        end
      end else if (in_valid && !skid_vld) begin
        load_skid  = 1'b1;
        skid_vld_n = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        main_vld <= 1'b0;
        skid_vld <= 1'b0;
      end else begin
        main_vld <= main_vld_n;
        skid_vld <= skid_vld_n;
      end
    end

    always_ff @(posedge clk) begin
      if (load_main) main_q <= in_data;
      else if (pop_skid) main_q <= skid_q;
      if (load_skid) skid_q <= in_data;
    end

  end else if (MODE == SLICE_HALF) begin : g_half

    logic             q_vld;
    logic [WIDTH-1:0] q_data;

    assign in_ready  = !q_vld;
    assign out_valid = q_vld;
    assign out_data  = q_data;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q_vld <= 1'b0;
      end else if (q_vld) begin
        if (out_ready) q_vld <= 1'b0;
      end else if (in_valid) begin
        q_vld <= 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (!q_vld && in_valid) q_data <= in_data;
    end

  end else begin : g_bad

    $error("axi_slice_chan: unsupported MODE %0d", MODE);

  end

endmodule

// File: rtl/axi_reg_slice.sv
// AXI4 point-to-point link with a selectable register stage per channel.
// Payload fields are packed per channel and carried through axi_slice_chan.
module axi_reg_slice
  import axi_slice_pkg::*;
#(
  parameter int          ID_WIDTH   = 2,
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 128,
  parameter slice_mode_e AW_MODE    = SLICE_FULL,
  parameter slice_mode_e W_MODE     = SLICE_FULL,
  parameter slice_mode_e B_MODE     = SLICE_FULL,
  parameter slice_mode_e AR_MODE    = SLICE_FULL,
  parameter slice_mode_e R_MODE     = SLICE_FULL
) (
  input logic             ACLOCK,
  input logic             ARESETN,
  axi_reg_slice_if.slave  s_axi,
  axi_reg_slice_if.master m_axi
);

  localparam int A_W = ID_WIDTH + ADDR_WIDTH + AXI_LEN_W
                     + AXI_SIZE_W + AXI_BURST_W + 1
                     + AXI_CACHE_W + AXI_PROT_W;
  localparam int W_W = DATA_WIDTH + DATA_WIDTH / 8 + 1;
  localparam int B_W = ID_WIDTH + AXI_RESP_W;
  localparam int R_W = ID_WIDTH + DATA_WIDTH + AXI_RESP_W + 1;

  logic [A_W-1:0] aw_in, aw_out;
  logic [W_W-1:0] w_in, w_out;
  logic [B_W-1:0] b_in, b_out;
  logic [A_W-1:0] ar_in, ar_out;
  logic [R_W-1:0] r_in, r_out;

  assign aw_in = {s_axi.aw_id, s_axi.aw_addr, s_axi.aw_len,
                  s_axi.aw_size, s_axi.aw_burst, s_axi.aw_lock,
                  s_axi.aw_cache, s_axi.aw_prot};
  assign {m_axi.aw_id, m_axi.aw_addr, m_axi.aw_len,
          m_axi.aw_size, m_axi.aw_burst, m_axi.aw_lock,
          m_axi.aw_cache, m_axi.aw_prot} = aw_out;

  assign w_in = {s_axi.w_data, s_axi.w_strb, s_axi.w_last};
  assign {m_axi.w_data, m_axi.w_strb, m_axi.w_last} = w_out;

  assign b_in = {m_axi.b_id, m_axi.b_resp};
  assign {s_axi.b_id, s_axi.b_resp} = b_out;

  assign ar_in = {s_axi.ar_id, s_axi.ar_addr, s_axi.ar_len,
                  s_axi.ar_size, s_axi.ar_burst, s_axi.ar_lock,
                  s_axi.ar_cache, s_axi.ar_prot};
  assign {m_axi.ar_id, m_axi.ar_addr, m_axi.ar_len,
          m_axi.ar_size, m_axi.ar_burst, m_axi.ar_lock,
          m_axi.ar_cache, m_axi.ar_prot} = ar_out;

  assign r_in = {m_axi.r_id, m_axi.r_data, m_axi.r_resp, m_axi.r_last};
  assign {s_axi.r_id, s_axi.r_data, s_axi.r_resp, s_axi.r_last} = r_out;

  axi_slice_chan #(.WIDTH(A_W), .MODE(AW_MODE)) u_aw (
    .clk      (ACLOCK),
    .rst_n    (ARESETN),
    .in_valid (s_axi.aw_valid),
    .in_ready (s_axi.aw_ready),
    .in_data  (aw_in),
    .out_valid(m_axi.aw_valid),
    .out_ready(m_axi.aw_ready),
    .out_data (aw_out)
  );

  axi_slice_chan #(.WIDTH(W_W), .MODE(W_MODE)) u_w (
    .clk      (ACLOCK),
    .rst_n    (ARESETN),
    .in_valid (s_axi.w_valid),
    .in_ready (s_axi.w_ready),
    .in_data  (w_in),
    .out_valid(m_axi.w_valid),
    .out_ready(m_axi.w_ready),
    .out_data (w_out)
  );

  // response channels run from the master port back to the slave port
  axi_slice_chan #(.WIDTH(B_W), .MODE(B_MODE)) u_b (
    .clk      (ACLOCK),
    .rst_n    (ARESETN),
    .in_valid (m_axi.b_valid),
    .in_ready (m_axi.b_ready),
    .in_data  (b_in),
    .out_valid(s_axi.b_valid),
    .out_ready(s_axi.b_ready),
    .out_data (b_out)
  );

  axi_slice_chan #(.WIDTH(A_W), .MODE(AR_MODE)) u_ar (
    .clk      (ACLOCK),
    .rst_n    (ARESETN),
    .in_valid (s_axi.ar_valid),
    .in_ready (s_axi.ar_ready),
    .in_data  (ar_in),
    .out_valid(m_axi.ar_valid),
    .out_ready(m_axi.ar_ready),
    .out_data (ar_out)
  );

  axi_slice_chan #(.WIDTH(R_W), .MODE(R_MODE)) u_r (
    .clk      (ACLOCK),
    .rst_n    (ARESETN),
    .in_valid (m_axi.r_valid),
    .in_ready (m_axi.r_ready),
    .in_data  (r_in),
    .out_valid(s_axi.r_valid),
    .out_ready(s_axi.r_ready),
    .out_data (r_out)
  );

endmodule

// File: tb/tb_axi_reg_slice.sv
// Directed and random-backpressure bench for axi_reg_slice.
// AW/W/AR full skid, B bypass, R half-rate.
module tb_axi_reg_slice;
  import axi_slice_pkg::*;

  logic ACLOCK = 1'b0;
  logic ARESETN = 1'b0;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  axi_reg_slice_if #(.ID_WIDTH(2), .ADDR_WIDTH(32), .DATA_WIDTH(128)) s_if ();
  axi_reg_slice_if #(.ID_WIDTH(2), .ADDR_WIDTH(32), .DATA_WIDTH(128)) m_if ();

  axi_reg_slice #(
    .ID_WIDTH  (2),
    .ADDR_WIDTH(32),
    .DATA_WIDTH(128),
    .AW_MODE   (SLICE_FULL),
    .W_MODE    (SLICE_FULL),
    .B_MODE    (SLICE_BYPASS),
    .AR_MODE   (SLICE_FULL),
    .R_MODE    (SLICE_HALF)
  ) dut (
    .ACLOCK (ACLOCK),
    .ARESETN(ARESETN),
    .s_axi  (s_if),
    .m_axi  (m_if)
  );

  always #5 ACLOCK = ~ACLOCK;

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // channel index: 0 AW, 1 W, 2 AR, 3 R
  function automatic int pw(input int ch);
    case (ch)
      0, 2:    pw = 55;
      1:       pw = 145;
      default: pw = 133;
    endcase
  endfunction

  task automatic drive_in(input int ch, input logic v, input logic [255:0] p);
    case (ch)
      0: begin
        s_if.aw_valid = v;
        {s_if.aw_id, s_if.aw_addr, s_if.aw_len, s_if.aw_size, s_if.aw_burst,
         s_if.aw_lock, s_if.aw_cache, s_if.aw_prot} = p[54:0];
      end
      1: begin
        s_if.w_valid = v;
        {s_if.w_data, s_if.w_strb, s_if.w_last} = p[144:0];
      end
      2: begin
        s_if.ar_valid = v;
        {s_if.ar_id, s_if.ar_addr, s_if.ar_len, s_if.ar_size, s_if.ar_burst,
         s_if.ar_lock, s_if.ar_cache, s_if.ar_prot} = p[54:0];
      end
      default: begin
        m_if.r_valid = v;
        {m_if.r_id, m_if.r_data, m_if.r_resp, m_if.r_last} = p[132:0];
      end
    endcase
  endtask

  task automatic set_out_ready(input int ch, input logic r);
    case (ch)
      0:       m_if.aw_ready = r;
      1:       m_if.w_ready = r;
      2:       m_if.ar_ready = r;
      default: s_if.r_ready = r;
    endcase
  endtask

  function automatic logic get_in_ready(input int ch);
    case (ch)
      0:       get_in_ready = s_if.aw_ready;
      1:       get_in_ready = s_if.w_ready;
      2:       get_in_ready = s_if.ar_ready;
      default: get_in_ready = m_if.r_ready;
    endcase
  endfunction

  function automatic logic get_out_valid(input int ch);
    case (ch)
      0:       get_out_valid = m_if.aw_valid;
      1:       get_out_valid = m_if.w_valid;
      2:       get_out_valid = m_if.ar_valid;
      default: get_out_valid = s_if.r_valid;
    endcase
  endfunction

  function automatic logic [255:0] get_out(input int ch);
    get_out = '0;
    case (ch)
      0: get_out[54:0] = {m_if.aw_id, m_if.aw_addr, m_if.aw_len, m_if.aw_size,
                          m_if.aw_burst, m_if.aw_lock, m_if.aw_cache,
                          m_if.aw_prot};
      1: get_out[144:0] = {m_if.w_data, m_if.w_strb, m_if.w_last};
      2: get_out[54:0] = {m_if.ar_id, m_if.ar_addr, m_if.ar_len, m_if.ar_size,
                          m_if.ar_burst, m_if.ar_lock, m_if.ar_cache,
                          m_if.ar_prot};
      default: get_out[132:0] = {s_if.r_id, s_if.r_data, s_if.r_resp,
                                 s_if.r_last};
    endcase
  endfunction

  // random valid/ready on both sides, in-order scoreboard, stall stability
  task automatic run_rand(input int ch, input int n);
    logic [255:0] q[$];
    logic [255:0] cur;
    logic [255:0] mask;
    logic [255:0] prev_out;
    logic         vld;
    logic         prev_stall;
    logic         ov;
    logic [255:0] op;
    int           sent;
    int           got;
    int           cyc;
    string        nm;
    nm = $sformatf("rand_ch%0d", ch);
    mask = (256'd1 << pw(ch)) - 256'd1;
    vld = 1'b0;
    prev_stall = 1'b0;
    prev_out = '0;
    cur = '0;
    sent = 0;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 20 * n) begin
      @(negedge ACLOCK);
      if (!vld && sent < n && $urandom_range(0, 3) != 0) begin
        for (int k = 0; k < 8; k++) cur[k*32 +: 32] = $urandom;
        cur = cur & mask;
        vld = 1'b1;
      end
      drive_in(ch, vld, cur);
      set_out_ready(ch, $urandom_range(0, 2) != 0);
      #1;
      ov = get_out_valid(ch);
      op = get_out(ch);
      if (prev_stall) begin
        chk({nm, "_hold_valid"}, ov, 1'b1);
        chk({nm, "_hold_data"}, op, prev_out);
      end
      if (vld && get_in_ready(ch)) begin
        q.push_back(cur);
        sent++;
        vld = 1'b0;
      end
      if (ov && (ch == 3 ? s_if.r_ready : (ch == 0 ? m_if.aw_ready :
                 (ch == 1 ? m_if.w_ready : m_if.ar_ready)))) begin
        chk({nm, "_nonempty"}, q.size() != 0, 1'b1);
        if (q.size() != 0) chk({nm, "_data"}, op, q.pop_front());
        got++;
      end else if (ov) begin
        prev_stall = 1'b1;
        prev_out = op;
        cyc++;
        continue;
      end
      prev_stall = 1'b0;
      cyc++;
    end
    chk({nm, "_count"}, got, n);
    @(negedge ACLOCK);
    drive_in(ch, 1'b0, '0);
    set_out_ready(ch, 1'b1);
  endtask

  logic [127:0] wb [4];
  logic         w_mr [8];
  logic         w_er [8];
  logic         w_ev [8];
  logic [128:0] w_ed [8];
  int           idx;
  int           got;

  initial begin
    drive_in(0, 1'b0, '0);
    drive_in(1, 1'b0, '0);
    drive_in(2, 1'b0, '0);
    drive_in(3, 1'b0, '0);
    m_if.b_valid = 1'b0;
    m_if.b_id = '0;
    m_if.b_resp = '0;
    s_if.b_ready = 1'b0;
    m_if.aw_ready = 1'b1;
    m_if.w_ready = 1'b1;
    m_if.ar_ready = 1'b1;
    s_if.r_ready = 1'b1;

    repeat (2) @(negedge ACLOCK);
    ARESETN = 1'b1;
    @(negedge ACLOCK);
    #1;
    chk("rst_aw_ready", s_if.aw_ready, 1'b1);
    chk("rst_w_ready", s_if.w_ready, 1'b1);
    chk("rst_ar_ready", s_if.ar_ready, 1'b1);
    chk("rst_r_ready", m_if.r_ready, 1'b1);
    chk("rst_b_ready", m_if.b_ready, 1'b0);
    chk("rst_aw_valid", m_if.aw_valid, 1'b0);
    chk("rst_w_valid", m_if.w_valid, 1'b0);
    chk("rst_ar_valid", m_if.ar_valid, 1'b0);
    chk("rst_b_valid", s_if.b_valid, 1'b0);
    chk("rst_r_valid", s_if.r_valid, 1'b0);

    // async reset between edges must clear a held beat at once
    @(negedge ACLOCK);
    m_if.aw_ready = 1'b0;
    s_if.aw_valid = 1'b1;
    s_if.aw_addr = 32'hDEAD0000;
    @(negedge ACLOCK);
    s_if.aw_valid = 1'b0;
    #1;
    chk("arst_pre_valid", m_if.aw_valid, 1'b1);
    #1;
    ARESETN = 1'b0;
    #1;
    chk("arst_valid", m_if.aw_valid, 1'b0);
    chk("arst_ready", s_if.aw_ready, 1'b1);
    @(negedge ACLOCK);
    ARESETN = 1'b1;
    m_if.aw_ready = 1'b1;
    #1;
    chk("arst_post_valid", m_if.aw_valid, 1'b0);

    // AW streaming at full rate
    for (int i = 0; i < 8; i++) begin
      @(negedge ACLOCK);
      s_if.aw_valid = 1'b1;
      s_if.aw_addr = 32'h1000 + 32'h10 * i;
      #1;
      chk("aw_seq_ready", s_if.aw_ready, 1'b1);
      if (i > 0) begin
        chk("aw_seq_valid", m_if.aw_valid, 1'b1);
        chk("aw_seq_addr", m_if.aw_addr, 32'h1000 + 32'h10 * (i - 1));
      end
    end
    @(negedge ACLOCK);
    s_if.aw_valid = 1'b0;
    #1;
    chk("aw_seq_valid", m_if.aw_valid, 1'b1);
    chk("aw_seq_addr", m_if.aw_addr, 32'h1070);
    @(negedge ACLOCK);
    #1;
    chk("aw_seq_drain", m_if.aw_valid, 1'b0);

    // W burst with two stalled cycles filling the skid
    wb = '{128'hA, 128'hB, 128'hC, 128'hD};
    w_mr = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    w_er = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    w_ev = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    w_ed = '{129'h0, {1'b0, 128'hA}, {1'b0, 128'hB}, {1'b0, 128'hB},
             {1'b0, 128'hB}, {1'b0, 128'hC}, {1'b1, 128'hD}, 129'h0};
    idx = 0;
    for (int t = 0; t < 8; t++) begin
      @(negedge ACLOCK);
      m_if.w_ready = w_mr[t];
      s_if.w_valid = idx < 4;
      s_if.w_data = idx < 4 ? wb[idx] : '0;
      s_if.w_last = idx == 3;
      s_if.w_strb = '1;
      #1;
      chk($sformatf("w_ready_t%0d", t), s_if.w_ready, w_er[t]);
      chk($sformatf("w_valid_t%0d", t), m_if.w_valid, w_ev[t]);
      if (w_ev[t])
        chk($sformatf("w_beat_t%0d", t), {m_if.w_last, m_if.w_data}, w_ed[t]);
      if (s_if.w_valid && s_if.w_ready) idx++;
    end
    s_if.w_valid = 1'b0;
    m_if.w_ready = 1'b1;

    // R half-rate: continuous source, every other cycle accepted
    idx = 0;
    got = 0;
    s_if.r_ready = 1'b1;
    for (int t = 0; t < 12; t++) begin
      @(negedge ACLOCK);
      m_if.r_valid = idx < 6;
      m_if.r_data = 128'(idx + 1);
      m_if.r_last = idx == 5;
      m_if.r_id = 2'd1;
      m_if.r_resp = 2'd0;
      #1;
      chk($sformatf("r_mready_t%0d", t), m_if.r_ready, (t % 2) == 0);
      chk($sformatf("r_svalid_t%0d", t), s_if.r_valid, (t % 2) == 1);
      if (t % 2 == 1)
        chk($sformatf("r_sdata_t%0d", t), s_if.r_data, 128'(t / 2 + 1));
      if (s_if.r_valid && s_if.r_ready) got++;
      if (m_if.r_valid && m_if.r_ready) idx++;
    end
    chk("r_beats", got, 6);
    m_if.r_valid = 1'b0;

    // B bypass is purely combinational
    @(negedge ACLOCK);
    m_if.b_valid = 1'b1;
    m_if.b_id = 2'd2;
    m_if.b_resp = 2'b10;
    s_if.b_ready = 1'b0;
    #1;
    chk("b_valid", s_if.b_valid, 1'b1);
    chk("b_id", s_if.b_id, 2'd2);
    chk("b_resp", s_if.b_resp, 2'b10);
    chk("b_ready_lo", m_if.b_ready, 1'b0);
    s_if.b_ready = 1'b1;
    #1;
    chk("b_ready_hi", m_if.b_ready, 1'b1);
    m_if.b_valid = 1'b0;
    #1;
    chk("b_valid_lo", s_if.b_valid, 1'b0);

    for (int ch = 0; ch < 4; ch++) run_rand(ch, 400);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/axi_reg_slice.md
Name: axi_reg_slice

Overview:
- Parametrised AXI4 point-to-point connection between one slave-side port (s_axi) and one master-side port (m_axi).
- Each of the five channels (AW, W, B, AR, R) gets an independently selectable register stage: bypass, full-throughput skid buffer, or half-throughput single register.
- Replaces fixed-width pure-wire NIC connections wherever timing closure needs channel pipelining.

Parameters:
- ID_WIDTH, 2: AXI ID width, all channels.
- ADDR_WIDTH, 32: AWADDR/ARADDR width.
- DATA_WIDTH, 128: WDATA/RDATA width, multiple of 8; STRB width = DATA_WIDTH/8.
- AW_MODE, SLICE_FULL: register mode of AW channel (SLICE_BYPASS=0, SLICE_FULL=1, SLICE_HALF=2).
- W_MODE, SLICE_FULL: register mode of W channel.
- B_MODE, SLICE_FULL: register mode of B channel.
- AR_MODE, SLICE_FULL: register mode of AR channel.
- R_MODE, SLICE_FULL: register mode of R channel.

Ports:
- ACLOCK  in  1  single clock, all logic rising-edge.
- ARESETN  in  1  asynchronous active-low reset.
- AW*_s_axi_*  in (READY out)  AXI4 AW set: ID, ADDR, LEN[7:0], SIZE[2:0], BURST[1:0], LOCK, CACHE[3:0], PROT[2:0], VALID; AWREADY out.
- W*_s_axi_*  in (READY out)  WDATA, WSTRB, WLAST, WVALID; WREADY out.
- B*_s_axi_*  out (READY in)  BID, BRESP[1:0], BVALID; BREADY in.
- AR*_s_axi_*  in (READY out)  same field set as AW; ARREADY out.
- R*_s_axi_*  out (READY in)  RID, RDATA, RRESP[1:0], RLAST, RVALID; RREADY in.
- m_axi side: identical signal set with mirrored directions.

Behaviour:
- Clock/reset: one clock, ACLOCK; reset asynchronous, active-low, ARESETN. Clears only control state (valid flags). Payload registers are not reset.
- Per-channel payload: concatenation of all non-handshake fields, passed unmodified, field order fixed in package. Forward channels (AW, W, AR) are s to m; backward channels (B, R) are m to s.
- SLICE_BYPASS: out = in combinationally, in_ready = out_ready. Zero latency, no state.
- SLICE_FULL: main register plus skid register, 2 entries.
  - in_ready = !skid_valid (registered, no combinational path from out_ready).
  - Latency 1 cycle; sustains 1 transfer/cycle.
  - Accept while main holding and out stalled: data goes to skid.
  - On out handshake: skid moves to main.
  - Simultaneous in-accept + out-handshake with main valid, skid empty: new data goes to main.
- SLICE_HALF: single register.
  - in_ready = !out_valid. Max 1 transfer per 2 cycles; latency 1.
- All modes: out_valid never drops and payload never changes while out_valid=1 and out_ready=0 (AXI stability).
- Reset values: every VALID output on both ports is 0. READY outputs are 1 for FULL/HALF (empty), mirror the opposite port for BYPASS.
- Reset mid-burst: in-flight beats are discarded and the channel is empty on the first cycle after deassertion. Upstream/downstream are reset by the same ARESETN.
- No reordering, no ID or burst interpretation, no cross-channel coupling. W beats may precede AW, as AXI permits.
- Invalid MODE value: elaboration-time $error.

Decomposition:
- Package axi_slice_pkg: enum slice_mode_e {SLICE_BYPASS, SLICE_FULL, SLICE_HALF}; constants AXI_LEN_W=8, AXI_SIZE_W=3, AXI_BURST_W=2, AXI_CACHE_W=4, AXI_PROT_W=3, AXI_RESP_W=2.
- Width-dependent payload packing is local to axi_reg_slice.
- Sub-module axi_slice_chan #(WIDTH, MODE): generic valid/ready/payload slice, instantiated 5 times with ACLOCK/ARESETN.

Test Plan:
- Reset, all modes FULL: after ARESETN rises, all m/s VALID=0 and all s-side/m-side READY=1. Drive ARESETN low asynchronously mid-cycle -> VALID clears immediately, not at the next edge.
- AW FULL, AWVALID held 1 with AWADDR=0x1000,0x1010,... for 8 cycles, m AWREADY=1 -> m AWADDR sequence identical, delayed 1 cycle, 8 beats in 8 cycles.
- W FULL, 4-beat burst WDATA=0xA..0xD, WLAST on 4th; m WREADY=0 on cycles 2-3 -> WREADY_s drops the cycle after the skid fills; all 4 beats and WLAST delivered in order, none lost or duplicated, payload stable while stalled.
- R HALF, m RVALID continuous with RDATA=1..6 -> s-side sees 6 beats over 12 cycles; RREADY_m alternates 1/0.
- B BYPASS, BID=2, BRESP=2'b10 -> BVALID_s same cycle, BREADY_m == BREADY_s combinationally.
- Random valid/ready backpressure, 10k transactions per channel, all-FULL and all-HALF -> scoreboard exact in-order match, no AXI stability violations (assertions).
